load_store_unit: RTL and testbench

Executes RV32I loads and stores for the core. It sits between the execute stage and the register file: it consumes the ALU-computed address and the rs2 read data, drives a req/gnt/rvalid data-memory port, and produces the write-back triple that drives the register file's write_enable/rd_addr/rd_wdata. The core stalls fetch while `req_ready` is low.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_align.sv | 77 +++++++
 rtl/load_store_unit.sv | 205 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
//   Shared constants for the RV32I load/store unit:
//     - LSU_XLEN                : data bus width (32)
//     - SIZE_B / SIZE_H / SIZE_W: req_size encodings (2'b11 is illegal)
//     - lsu_state_t + ST_*      : FSM state encoding (IDLE, REQ, WAIT)
//     - lsu_misaligned()        : natural-alignment test for a size/offset pair
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam int unsigned LSU_XLEN = 32;

    localparam logic [1:0] SIZE_B       = 2'b00;
    localparam logic [1:0] SIZE_H       = 2'b01;
    localparam logic [1:0] SIZE_W       = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef logic [1:0] lsu_state_t;

    localparam lsu_state_t ST_IDLE = 2'd0;
    localparam lsu_state_t ST_REQ  = 2'd1;
    localparam lsu_state_t ST_WAIT = 2'd2;

    // True when the access does not sit on its natural boundary.
    function automatic logic lsu_misaligned(input logic [1:0] size,
                                            input logic [1:0] offset);
        return ((size == SIZE_H) && offset[0]) ||
               ((size == SIZE_W) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
//   Combinational lane steering for the load/store unit.
//   The lane offset is truncated to natural alignment (half uses addr[1] only,
//   word always uses lane 0); misaligned requests are filtered upstream when
//   alignment checking is built in.
//   Ports:
//     size_i        access size (SIZE_B/H/W, 2'b11 illegal)
//     offset_i      byte offset addr[1:0]
//     is_unsigned_i zero-extend (LBU/LHU) instead of sign-extend
//     wdata_i       raw store data (rs2)
//     rdata_i       raw read data word from the bus
//     be_o          byte enables
//     wdata_o       lane-replicated store data
//     rdata_o       extracted and extended load data
// -----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]          size_i,
    input  logic [1:0]          offset_i,
    input  logic                is_unsigned_i,
    input  logic [LSU_XLEN-1:0] wdata_i,
    input  logic [LSU_XLEN-1:0] rdata_i,
    output logic [3:0]          be_o,
    output logic [LSU_XLEN-1:0] wdata_o,
    output logic [LSU_XLEN-1:0] rdata_o
);

    logic [1:0]          eff_off;
    logic [LSU_XLEN-1:0] shifted;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave a value held (a latch).
    always_comb begin
        eff_off = 2'b00;
        be_o    = 4'b0000;
        wdata_o = '0;
        unique case (size_i)
            SIZE_B: begin
                eff_off = offset_i;
                be_o    = 4'b0001 << offset_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SIZE_H: begin
                eff_off = {offset_i[1], 1'b0};
                be_o    = 4'b0011 << {offset_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
            end
            SIZE_W: begin
                eff_off = 2'b00;
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
            default: begin
                eff_off = 2'b00;
                be_o    = 4'b0000;
                wdata_o = '0;
            end
        endcase
    end

    // Move the addressed lane down to bit 0 before extension.
    assign shifted = rdata_i >> {eff_off, 3'b000};

    always_comb begin
        rdata_o = rdata_i;
        unique case (size_i)
            SIZE_B:  rdata_o = is_unsigned_i ? {24'h0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_H:  rdata_o = is_unsigned_i ? {16'h0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Executes RV32I loads/stores between the execute stage and the register
//   file over a req/gnt/rvalid data-memory port.
//   Build option: define LSU_MISALIGN_CHECK_EN to reject misaligned half/word
//   accesses with err; otherwise the offset is truncated to natural alignment.
//   Parameter:
//     TIMEOUT_CYCLES  cycles allowed in REQ or WAIT before aborting (0 = off)
//   Ports:
//     clk, rst_n                 clock, synchronous active-low reset
//     req_valid/req_ready        op handshake from the core (ready = idle)
//     req_we/size/unsigned/addr/wdata/rd   the op itself
//     mem_req/gnt/addr/we/be/wdata/rvalid/rdata   data-memory port
//     wb_en/wb_addr/wb_data      register-file write-back (one-cycle strobe)
//     done/err                   completion / abort pulses
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        done,
    output logic        err
);

    localparam logic [15:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[15:0];

    lsu_state_t  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;

    // Captured request.
    logic        we_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;

    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        wb_en_q, wb_en_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d;

    logic        accept;
    logic        misaligned;
    logic        reject;
    logic        timeout_hit;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic [31:0] load_data;

`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned = lsu_misaligned(req_size, req_addr[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign accept = (state_q == ST_IDLE) && req_valid;
    assign reject = (req_size == SIZE_ILLEGAL) || misaligned;

    // cnt_q counts whole cycles spent in the current state without the awaited
    // event; the abort fires at the end of cycle number TIMEOUT_CYCLES.
    assign timeout_hit = (TIMEOUT_LIMIT != 16'd0) &&
                         (cnt_q == TIMEOUT_LIMIT - 16'd1);

    lsu_align u_align (
        .size_i        (size_q),
        .offset_i      (addr_q[1:0]),
        .is_unsigned_i (unsigned_q),
        .wdata_i       (wdata_q),
        .rdata_i       (mem_rdata),
        .be_o          (be),
        .wdata_o       (wdata_rep),
        .rdata_o       (load_data)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        cnt_d   = 16'd0;
                    end
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    if (we_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 16'd0;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    // x0 is hardwired to zero: complete the op, skip the write.
                    if (rd_q != 5'd0) begin
                        wb_en_d   = 1'b1;
                        wb_addr_d = rd_q;
                        wb_data_d = load_data;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 16'd0;
            we_q       <= 1'b0;
            size_q     <= SIZE_B;
            unsigned_q <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rd_q       <= 5'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_addr_q  <= 5'd0;
            wb_data_q  <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            if (accept) begin
                we_q       <= req_we;
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                rd_q       <= req_rd;
            end
        end
    end

    // Bus fields are forced to zero outside REQ so the port is quiet when idle.
    assign req_ready = (state_q == ST_IDLE);
    assign mem_req   = (state_q == ST_REQ);
    assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_we    = mem_req & we_q;
    assign mem_be    = mem_req ? be : 4'b0000;
    assign mem_wdata = (mem_req && we_q) ? wdata_rep : 32'h0;

    assign wb_en   = wb_en_q;
    assign wb_addr = wb_addr_q;
    assign wb_data = wb_data_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Directed bench for load_store_unit (TIMEOUT_CYCLES = 4). Inputs change and
//   outputs are sampled on the falling clock edge; the DUT acts on the rising
//   edge. Expected values are hand-computed constants.
//   Honours LSU_MISALIGN_CHECK_EN to pick the misaligned-access expectations.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .mem_req      (mem_req),
        .mem_gnt      (mem_gnt),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .done         (done),
        .err          (err)
    );

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_rd       = rd;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        tick(); tick();

        // ---- reset values ----
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_mem_req",   32'(mem_req),   32'd0);
        check("rst_mem_addr",  mem_addr,       32'h0);
        check("rst_mem_be",    32'(mem_be),    32'h0);
        check("rst_mem_we",    32'(mem_we),    32'd0);
        check("rst_mem_wdata", mem_wdata,      32'h0);
        check("rst_wb_en",     32'(wb_en),     32'd0);
        check("rst_wb_addr",   32'(wb_addr),   32'd0);
        check("rst_wb_data",   wb_data,        32'h0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_err",       32'(err),       32'd0);
        rst_n = 1'b1;
        tick();

        // ---- store byte 0x1003, immediate gnt ----
        issue(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'hAABB_CCDD, 5'd0);
        tick();
        req_valid = 1'b0;
        check("sb_ready_low", 32'(req_ready), 32'd0);
        check("sb_mem_req",   32'(mem_req),   32'd1);
        check("sb_mem_addr",  mem_addr,       32'h0000_1000);
        check("sb_mem_be",    32'(mem_be),    32'h8);
        check("sb_mem_wdata", mem_wdata,      32'hDDDD_DDDD);
        check("sb_mem_we",    32'(mem_we),    32'd1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("sb_done",      32'(done),      32'd1);
        check("sb_no_err",    32'(err),       32'd0);
        check("sb_no_wb",     32'(wb_en),     32'd0);
        check("sb_req_drop",  32'(mem_req),   32'd0);
        check("sb_ready",     32'(req_ready), 32'd1);
        tick();
        check("sb_done_pulse", 32'(done),     32'd0);

        // ---- load signed half 0x2002 -> x5, gnt delayed 3 cycles ----
        issue(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 5'd5);
        tick();
        req_valid = 1'b0;
        check("lh_mem_addr", mem_addr,    32'h0000_2000);
        check("lh_mem_be",   32'(mem_be), 32'hC);
        check("lh_mem_we",   32'(mem_we), 32'd0);
        tick();
        check("lh_req_hold1", 32'(mem_req), 32'd1);
        check("lh_addr_hold", mem_addr,     32'h0000_2000);
        tick();
        check("lh_req_hold2", 32'(mem_req), 32'd1);
        tick();
        check("lh_req_hold3", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("lh_wait_req", 32'(mem_req),   32'd0);
        check("lh_wait_rdy", 32'(req_ready), 32'd0);
        check("lh_wait_done", 32'(done),     32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h8001_1234;
        tick();
        mem_rvalid = 1'b0;
        check("lh_wb_en",   32'(wb_en),   32'd1);
        check("lh_wb_addr", 32'(wb_addr), 32'd5);
        check("lh_wb_data", wb_data,      32'hFFFF_8001);
        check("lh_done",    32'(done),    32'd1);

        // ---- LBU 0x2003 -> x7, issued back-to-back in the done cycle ----
        issue(1'b0, 2'b00, 1'b1, 32'h0000_2003, 32'h0, 5'd7);
        tick();
        req_valid = 1'b0;
        check("lbu_b2b_req", 32'(mem_req),   32'd1);
        check("lbu_wb_off",  32'(wb_en),     32'd0);
        check("lbu_mem_be",  32'(mem_be),    32'h8);
        mem_gnt = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h8001_1234;
        tick();
        mem_rvalid = 1'b0;
        check("lbu_wb_en",   32'(wb_en),   32'd1);
        check("lbu_wb_addr", 32'(wb_addr), 32'd7);
        check("lbu_wb_data", wb_data,      32'h0000_0080);

        // ---- LB signed at lane 1 -> x2: 0x1234F0xx -> 0xFFFFFFF0 ----
        issue(1'b0, 2'b00, 1'b0, 32'h0000_2001, 32'h0, 5'd2);
        tick();
        req_valid = 1'b0;
        check("lb_mem_be", 32'(mem_be), 32'h2);
        mem_gnt = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_F055;
        tick();
        mem_rvalid = 1'b0;
        check("lb_wb_data", wb_data, 32'hFFFF_FFF0);
        tick();
        check("lb_wb_pulse", 32'(wb_en), 32'd0);

        // ---- load word to x0: bus read happens, no write-back ----
        issue(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 5'd0);
        tick();
        req_valid = 1'b0;
        check("x0_mem_req", 32'(mem_req), 32'd1);
        check("x0_mem_be",  32'(mem_be),  32'hF);
        mem_gnt = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        tick();
        mem_rvalid = 1'b0;
        check("x0_done",  32'(done),  32'd1);
        check("x0_no_wb", 32'(wb_en), 32'd0);
        tick();

        // ---- misaligned word store at 0x3001 ----
        issue(1'b1, 2'b10, 1'b0, 32'h0000_3001, 32'h1122_3344, 5'd0);
        tick();
        req_valid = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        check("mis_err",     32'(err),       32'd1);
        check("mis_no_req",  32'(mem_req),   32'd0);
        check("mis_ready",   32'(req_ready), 32'd1);
        check("mis_no_done", 32'(done),      32'd0);
        tick();
        check("mis_err_pulse", 32'(err),     32'd0);
        check("mis_no_req2",   32'(mem_req), 32'd0);
`else
        check("mis_no_err",   32'(err),    32'd0);
        check("mis_mem_req",  32'(mem_req), 32'd1);
        check("mis_mem_be",   32'(mem_be), 32'hF);
        check("mis_mem_addr", mem_addr,    32'h0000_3000);
        check("mis_mem_wdata", mem_wdata,  32'h1122_3344);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("mis_done", 32'(done), 32'd1);
`endif
        tick();

        // ---- illegal size 2'b11 ----
        issue(1'b1, 2'b11, 1'b0, 32'h0000_5000, 32'h0, 5'd0);
        tick();
        req_valid = 1'b0;
        check("ill_err",    32'(err),       32'd1);
        check("ill_no_req", 32'(mem_req),   32'd0);
        check("ill_ready",  32'(req_ready), 32'd1);
        tick();
        check("ill_err_pulse", 32'(err), 32'd0);

        // ---- timeout: gnt held low, 4 cycles in REQ then err ----
        issue(1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0, 5'd3);
        tick();
        req_valid = 1'b0;
        check("to_req_c1", 32'(mem_req), 32'd1);
        tick();
        check("to_req_c2", 32'(mem_req), 32'd1);
        tick();
        check("to_req_c3", 32'(mem_req), 32'd1);
        tick();
        check("to_req_c4", 32'(mem_req), 32'd1);
        check("to_no_err_yet", 32'(err), 32'd0);
        tick();
        check("to_err",     32'(err),       32'd1);
        check("to_req_off", 32'(mem_req),   32'd0);
        check("to_ready",   32'(req_ready), 32'd1);
        check("to_no_done", 32'(done),      32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 1'b0;
        check("to_late_no_wb",   32'(wb_en), 32'd0);
        check("to_late_no_done", 32'(done),  32'd0);

        // ---- reset while in WAIT ----
        issue(1'b0, 2'b10, 1'b0, 32'h0000_7000, 32'h0, 5'd9);
        tick();
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("rw_in_wait", 32'(req_ready), 32'd0);
        rst_n      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0011;
        tick();
        rst_n      = 1'b1;
        mem_rvalid = 1'b0;
        check("rw_ready",   32'(req_ready), 32'd1);
        check("rw_mem_req", 32'(mem_req),   32'd0);
        check("rw_no_wb",   32'(wb_en),     32'd0);
        check("rw_no_done", 32'(done),      32'd0);
        check("rw_no_err",  32'(err),       32'd0);
        tick();
        check("rw_still_no_wb", 32'(wb_en), 32'd0);

        // ---- store half at 0x8002: upper lanes, replicated data ----
        issue(1'b1, 2'b01, 1'b0, 32'h0000_8002, 32'h1234_BEEF, 5'd0);
        tick();
        req_valid = 1'b0;
        check("sh_mem_be",    32'(mem_be), 32'hC);
        check("sh_mem_wdata", mem_wdata,   32'hBEEF_BEEF);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("sh_done", 32'(done), 32'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
